// File: rtl/pmips_pkg.sv
// ---------------------------------------------------------------------------
// pmips_pkg -- shared constants and types for the pMIPS fetch stage.
//   WORD_W          : datapath / instruction width (16)
//   OP_BEQ, OP_ADDI : opcode field values used by the decode side
//   NOP_INSTR_DEF   : bubble instruction word (add $0,$0,$0)
//   fetch_state_t   : fetch FSM encoding (BOOT/RUN/HOLD, 2'd3 is illegal)
//   branch_target() : PC-relative branch target helper
// ---------------------------------------------------------------------------
package pmips_pkg;

    localparam int          WORD_W        = 16;
    localparam logic [2:0]  OP_BEQ        = 3'd2;
    localparam logic [2:0]  OP_ADDI       = 3'd3;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_ILLEGAL = 2'd3
    } fetch_state_t;

    // Target = pcplus2 + (sign-extended word offset << 1), wrapping modulo 2^16.
    function automatic logic [WORD_W-1:0] branch_target(
        input logic [WORD_W-1:0] pcplus2,
        input logic [6:0]        offset
    );
        return pcplus2 + {{8{offset[6]}}, offset, 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if -- signal bundle between the fetch stage and its
// environment (instruction memory, ID hazard/branch logic, debug monitor).
//   imemaddr      : instruction memory address (stage -> memory)
//   imemrdata     : instruction memory read data (memory -> stage)
//   stall         : hold request from ID
//   branch_taken  : branch resolved taken in ID
//   branch_offset : signed word offset of the branch in IF/ID
//   ifid_instr    : IF/ID instruction register
//   ifid_pcplus2  : IF/ID fetch PC + 2
//   ifid_valid    : IF/ID holds a real instruction
//   fetch_state   : FSM state for the debug monitor
// Modports: master = fetch stage side, slave = environment side.
// ---------------------------------------------------------------------------
interface if_fetch_stage_if
    import pmips_pkg::*;
    ();

    logic [WORD_W-1:0] imemaddr;
    logic [WORD_W-1:0] imemrdata;
    logic              stall;
    logic              branch_taken;
    logic [6:0]        branch_offset;
    logic [WORD_W-1:0] ifid_instr;
    logic [WORD_W-1:0] ifid_pcplus2;
    logic              ifid_valid;
    logic [1:0]        fetch_state;

    modport master (
        output imemaddr, ifid_instr, ifid_pcplus2, ifid_valid, fetch_state,
        input  imemrdata, stall, branch_taken, branch_offset
    );

    modport slave (
        input  imemaddr, ifid_instr, ifid_pcplus2, ifid_valid, fetch_state,
        output imemrdata, stall, branch_taken, branch_offset
    );

endinterface

// File: rtl/ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg -- IF/ID pipeline register.
//   clock, reset : clock and asynchronous active-high reset
//   i_load       : capture i_instr / i_pcplus2 and mark valid
//   i_flush      : replace the instruction with a bubble (wins over i_load)
//   i_instr      : fetched instruction word
//   i_pcplus2    : fetch PC + 2
//   o_instr, o_pcplus2, o_valid : registered IF/ID contents
// A flush leaves pcplus2 untouched; only instr and valid change.
// ---------------------------------------------------------------------------
module ifid_reg
    import pmips_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic [WORD_W-1:0] i_instr,
    input  logic [WORD_W-1:0] i_pcplus2,
    output logic [WORD_W-1:0] o_instr,
    output logic [WORD_W-1:0] o_pcplus2,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_pcplus2;
    logic              r_valid;

    // IF/ID storage: flush inserts a bubble, load captures a real fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instr   <= NOP_INSTR;
            r_pcplus2 <= 16'h0000;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_instr   <= i_instr;
            r_pcplus2 <= i_pcplus2;
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus2 = r_pcplus2;
    assign o_valid   = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage -- pMIPS instruction fetch stage with IF/ID register.
//   clock     : single clock, rising edge
//   reset     : asynchronous active-high reset
//   bus       : if_fetch_stage_if.master (memory, stall/branch, IF/ID, state)
//   fetch_count [15:0] : only when IF_FETCH_COUNT_EN is defined; counts
//                        edges that load a valid instruction, wraps at 2^16
// FSM: BOOT (one settling cycle after reset, inserts a bubble), RUN
// (fetching), HOLD (stalled). The illegal encoding falls back to BOOT.
// A taken branch is only honoured when IF/ID holds a real instruction,
// and it overrides a simultaneous stall.
// ---------------------------------------------------------------------------
module if_fetch_stage
    import pmips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clock,
    input  logic              reset,
    if_fetch_stage_if.master  bus
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [WORD_W-1:0] fetch_count
`endif
);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_next_pc;
    logic [WORD_W-1:0] w_pcplus2;
    logic [WORD_W-1:0] w_target;
    logic              w_load;
    logic              w_flush;
    logic              w_branch;
    logic [WORD_W-1:0] w_ifid_instr;
    logic [WORD_W-1:0] w_ifid_pcplus2;
    logic              w_ifid_valid;

    assign w_pcplus2 = r_pc + 16'd2;
    assign w_target  = branch_target(w_ifid_pcplus2, bus.branch_offset);
    // A bubble in IF/ID carries no branch, so a taken flag against it is ignored.
    assign w_branch  = bus.branch_taken & w_ifid_valid;

    // Next-state, next-PC and IF/ID control decode.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_flush      = 1'b1;
                w_next_state = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (w_branch) begin
                    w_next_pc    = w_target;
                    w_flush      = 1'b1;
                    w_next_state = ST_RUN;
                end else if (bus.stall) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_pc    = w_pcplus2;
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase
    end

    // State and PC registers; PC bit 0 is forced low so fetches stay aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_pc    <= {RESET_PC[WORD_W-1:1], 1'b0};
        end else begin
            r_state <= w_next_state;
            r_pc    <= {w_next_pc[WORD_W-1:1], 1'b0};
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_load),
        .i_flush   (w_flush),
        .i_instr   (bus.imemrdata),
        .i_pcplus2 (w_pcplus2),
        .o_instr   (w_ifid_instr),
        .o_pcplus2 (w_ifid_pcplus2),
        .o_valid   (w_ifid_valid)
    );

`ifdef IF_FETCH_COUNT_EN
    logic [WORD_W-1:0] r_fetch_count;

    // Valid-load counter; load and flush are never both set, so load alone marks a valid capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_count <= 16'h0000;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    assign bus.imemaddr     = r_pc;
    assign bus.ifid_instr   = w_ifid_instr;
    assign bus.ifid_pcplus2 = w_ifid_pcplus2;
    assign bus.ifid_valid   = w_ifid_valid;
    assign bus.fetch_state  = r_state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage -- directed self-checking bench for if_fetch_stage.
// Instruction memory is a bench function of the address; every expected
// value below is hand-derived from that function and the fetch rules.
// Define IF_FETCH_COUNT_EN to also exercise the fetch counter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch_stage;
    import pmips_pkg::*;

    logic clock;
    logic reset;
    int   n_total;
    int   n_pass;

    if_fetch_stage_if bus ();

`ifdef IF_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    if_fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef IF_FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    // Instruction memory contents: address 0 holds addi $1,$0,3.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        if (a == 16'h0000) return 16'h6083;
        else               return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    assign bus.imemrdata = mem_f(bus.imemaddr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 7'd0;

        #12;
        chk("rst_addr",  bus.imemaddr, 16'h0000);
        chk("rst_instr", bus.ifid_instr, 16'h0000);
        chk("rst_pc2",   bus.ifid_pcplus2, 16'h0000);
        chk("rst_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        chk("rst_state", {14'd0, bus.fetch_state}, 16'h0000);
`ifdef IF_FETCH_COUNT_EN
        chk("rst_count", fetch_count, 16'h0000);
`endif
        reset = 1'b0;
        #1;

        // BOOT cycle: PC holds, bubble in IF/ID
        tick();
        chk("boot_addr",  bus.imemaddr, 16'h0000);
        chk("boot_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        chk("boot_state", {14'd0, bus.fetch_state}, 16'h0001);

        // first fetch
        tick();
        chk("f0_instr", bus.ifid_instr, 16'h6083);
        chk("f0_pc2",   bus.ifid_pcplus2, 16'h0002);
        chk("f0_addr",  bus.imemaddr, 16'h0002);
        chk("f0_valid", {15'd0, bus.ifid_valid}, 16'h0001);
`ifdef IF_FETCH_COUNT_EN
        chk("f0_count", fetch_count, 16'h0001);
`endif

        tick();
        chk("f1_addr",  bus.imemaddr, 16'h0004);
        chk("f1_pc2",   bus.ifid_pcplus2, 16'h0004);
        chk("f1_instr", bus.ifid_instr, mem_f(16'h0002));
        chk("f1_valid", {15'd0, bus.ifid_valid}, 16'h0001);

        tick();
        chk("f2_addr",  bus.imemaddr, 16'h0006);
        chk("f2_pc2",   bus.ifid_pcplus2, 16'h0006);
        chk("f2_instr", bus.ifid_instr, mem_f(16'h0004));
`ifdef IF_FETCH_COUNT_EN
        chk("f2_count", fetch_count, 16'h0003);
`endif

        // stall for 3 cycles: everything holds
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_addr",  bus.imemaddr, 16'h0006);
            chk("st_instr", bus.ifid_instr, mem_f(16'h0004));
            chk("st_pc2",   bus.ifid_pcplus2, 16'h0006);
            chk("st_state", {14'd0, bus.fetch_state}, 16'h0002);
        end
        bus.stall = 1'b0;
        tick();
        chk("rel_addr",  bus.imemaddr, 16'h0008);
        chk("rel_instr", bus.ifid_instr, mem_f(16'h0006));
        chk("rel_pc2",   bus.ifid_pcplus2, 16'h0008);
        chk("rel_state", {14'd0, bus.fetch_state}, 16'h0001);

        // taken branch, offset -2 words: 8 - 4 = 4
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 7'b1111110;
        tick();
        chk("br_addr",  bus.imemaddr, 16'h0004);
        chk("br_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        chk("br_instr", bus.ifid_instr, 16'h0000);
        chk("br_state", {14'd0, bus.fetch_state}, 16'h0001);

        // branch flag against a bubble is ignored: normal fetch from 4
        bus.branch_offset = 7'd5;
        tick();
        chk("brign_addr",  bus.imemaddr, 16'h0006);
        chk("brign_instr", bus.ifid_instr, mem_f(16'h0004));
        chk("brign_pc2",   bus.ifid_pcplus2, 16'h0006);
        chk("brign_valid", {15'd0, bus.ifid_valid}, 16'h0001);
`ifdef IF_FETCH_COUNT_EN
        chk("brign_count", fetch_count, 16'h0005);
`endif

        // stall and branch together: branch wins, target 6 + 6 = 12
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 7'd3;
        tick();
        chk("sb_addr",  bus.imemaddr, 16'h000C);
        chk("sb_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        chk("sb_state", {14'd0, bus.fetch_state}, 16'h0001);
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        tick();
        chk("sb2_addr",  bus.imemaddr, 16'h000E);
        chk("sb2_instr", bus.ifid_instr, mem_f(16'h000C));
        chk("sb2_pc2",   bus.ifid_pcplus2, 16'h000E);

        // asynchronous reset between edges
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ar_addr",  bus.imemaddr, 16'h0000);
        chk("ar_instr", bus.ifid_instr, 16'h0000);
        chk("ar_pc2",   bus.ifid_pcplus2, 16'h0000);
        chk("ar_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        chk("ar_state", {14'd0, bus.fetch_state}, 16'h0000);
`ifdef IF_FETCH_COUNT_EN
        chk("ar_count", fetch_count, 16'h0000);
`endif
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("rb_addr",  bus.imemaddr, 16'h0000);
        chk("rb_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        chk("rb_state", {14'd0, bus.fetch_state}, 16'h0001);

        // free-run to the top of the address space and across the wrap
        repeat (32767) tick();
        chk("wr_addr_top", bus.imemaddr, 16'hFFFE);
        chk("wr_pc2_top",  bus.ifid_pcplus2, 16'hFFFE);
        tick();
        chk("wr_addr0",  bus.imemaddr, 16'h0000);
        chk("wr_pc2_0",  bus.ifid_pcplus2, 16'h0000);
        chk("wr_instr",  bus.ifid_instr, mem_f(16'hFFFE));
        chk("wr_valid",  {15'd0, bus.ifid_valid}, 16'h0001);
`ifdef IF_FETCH_COUNT_EN
        chk("wr_count", fetch_count, 16'h8000);
        repeat (32767) tick();
        chk("cnt_top", fetch_count, 16'hFFFF);
        tick();
        chk("cnt_wrap", fetch_count, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000, instruction word (add $0,$0,$0) inserted as a bubble.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imemaddr  output  16  instruction memory address; equals the PC register.
REQ-006 imemrdata  input  16  instruction memory read data; combinational function of imemaddr.
REQ-007 stall  input  1  hold request from the ID hazard logic.
REQ-008 branch_taken  input  1  branch resolved taken in ID this cycle.
REQ-009 branch_offset  input  7  signed word offset from the instruction in IF/ID (bits [6:0] of beq).
REQ-010 ifid_instr  output  16  IF/ID instruction register.
REQ-011 ifid_pcplus2  output  16  IF/ID copy of fetch PC + 2.
REQ-012 ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-013 fetch_state  output  2  current FSM state, for the debug monitor.

Function
REQ-014 The FSM SHALL have the states BOOT=2'd0, RUN=2'd1 and HOLD=2'd2; 2'd3 is illegal and SHALL recover to BOOT on the next edge.
REQ-015 The BOOT state SHALL last exactly one cycle after reset deasserts: the PC holds at RESET_PC, IF/ID loads NOP_INSTR with valid=0, and the next state is RUN.
REQ-016 In RUN with stall=0 and branch_taken=0, each edge SHALL load pc <= pc+2, ifid_instr <= imemrdata, ifid_pcplus2 <= pc+2 and ifid_valid <= 1.
REQ-017 When stall=1 and branch_taken=0, the PC and all IF/ID registers SHALL hold, and the state SHALL become or remain HOLD.
REQ-018 In HOLD with stall=0, the next edge SHALL perform the REQ-016 update and the state SHALL return to RUN; no instruction is lost or duplicated.
REQ-019 The branch target SHALL be ifid_pcplus2 + {sign-extended branch_offset, 1'b0}, computed in 16 bits modulo 2^16.
REQ-020 When branch_taken=1 in RUN or HOLD, the edge SHALL load pc <= target, ifid_instr <= NOP_INSTR and ifid_valid <= 0, and the state SHALL become RUN.
REQ-021 branch_taken SHALL take priority over stall when both are asserted.
REQ-022 branch_taken SHALL be ignored while ifid_valid=0 or while in BOOT.
REQ-023 PC+2 SHALL wrap from 16'hFFFE to 16'h0000 with no flag.
REQ-024 Bit 0 of the PC SHALL always be 0.

Reset
REQ-025 While reset=1, independent of clock: pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pcplus2=0, ifid_valid=0, state=BOOT.
REQ-026 Reset asserted mid-operation (RUN, HOLD, or an in-flight branch) SHALL discard all state immediately; the first edge after deassertion SHALL be a BOOT cycle.

Configuration
REQ-027 With the macro IF_FETCH_COUNT_EN defined, the block SHALL add the output port fetch_count [15:0], counting edges that load ifid_valid<=1, reset to 0 and wrapping from 16'hFFFF to 0.
REQ-028 Without IF_FETCH_COUNT_EN, the fetch_count port and its counter SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-029 The shared package pmips_pkg SHALL hold the WORD_W=16 constant, the opcode constants (beq=3'd2, addi=3'd3), the NOP_INSTR value and the fetch-state enumeration.
REQ-030 The IF/ID register (instr, pcplus2, valid, with load and flush controls) SHALL be a single sub-module named ifid_reg.

Verification
REQ-031 Reset with imemrdata=16'h6083 (addi $1,$0,3): expect imemaddr=0 and ifid_valid=0 for one BOOT cycle; then ifid_instr=16'h6083, ifid_pcplus2=2 and imemaddr=2 after the next edge.
REQ-032 Free-run for 4 cycles: expect imemaddr sequence 2,4,6,8, ifid_pcplus2 tracking PC+2, and ifid_valid=1 throughout.
REQ-033 Assert stall for 3 cycles with ifid_pcplus2=6: expect imemaddr=6, ifid unchanged and fetch_state=HOLD; on release, the next instruction is latched exactly once.
REQ-034 With ifid_pcplus2=8, assert branch_taken with branch_offset=7'b1111110: expect imemaddr=4 and ifid_valid=0 after the edge, then a valid fetch from address 4.
REQ-035 Assert stall and branch_taken together: the branch wins and the state becomes RUN. Assert reset asynchronously between edges: outputs clear at once, without waiting for a clock.
REQ-036 Force the PC to 16'hFFFE: the next imemaddr is 0. With IF_FETCH_COUNT_EN defined, fetch_count equals the number of valid loads, including the wrap from 16'hFFFF to 0.
